demux1to3: RTL and testbench

DEMUX1TO3 -- requirements
Module: demux1to3

---
 rtl/demux_pkg.sv | 17 +
 rtl/out_slot.sv | 36 +++
 rtl/demux1to3.sv | 101 ++++++++++
 tb/tb_demux1to3.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared constants for the 1-to-3 demultiplexer: select encodings, default widths and
// the saturating increment used by the drop counter.
package demux_pkg;

  localparam logic [1:0] SEL_A   = 2'b00;
  localparam logic [1:0] SEL_B   = 2'b01;
  localparam logic [1:0] SEL_C   = 2'b10;
  localparam logic [1:0] SEL_INV = 2'b11;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned ERR_W = 8;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v == {ERR_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/out_slot.sv
// One-entry output register slice: loads on i_load, drains when the consumer is ready.
// The parent only asserts i_load when o_free is high.
module out_slot #(
  parameter int unsigned WIDTH = demux_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_free
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;

  // A load wins over a drain so a simultaneous drain+load keeps the slot full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_valid <= 1'b1;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_free  = !r_valid || i_ready;

endmodule

// File: rtl/demux1to3.sv
// Routes each accepted word to one of three registered output slots; invalid-select
// words are drained, dropped and counted.
module demux1to3 #(
  parameter int unsigned WIDTH = demux_pkg::WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           in_data,
  input  logic [1:0]                 sel,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           out_a,
  output logic [WIDTH-1:0]           out_b,
  output logic [WIDTH-1:0]           out_c,
  output logic                       valid_a,
  output logic                       valid_b,
  output logic                       valid_c,
  input  logic                       ready_a,
  input  logic                       ready_b,
  input  logic                       ready_c,
  output logic                       err_pulse,
  output logic [demux_pkg::ERR_W-1:0] err_count
);

  import demux_pkg::*;

  logic [2:0]       w_free;
  logic [2:0]       w_load;
  logic             w_accept;
  logic             w_drop;
  logic             r_err_pulse;
  logic [ERR_W-1:0] r_err_count;

  // Readiness depends only on the selected slot, never on in_valid.
  always_comb begin
    in_ready = 1'b0;
    if (!rst) begin
      case (sel)
        SEL_A:   in_ready = w_free[0];
        SEL_B:   in_ready = w_free[1];
        SEL_C:   in_ready = w_free[2];
        default: in_ready = 1'b1;
      endcase
    end
  end

  assign w_accept  = in_valid && in_ready;
  assign w_load[0] = w_accept && (sel == SEL_A);
  assign w_load[1] = w_accept && (sel == SEL_B);
  assign w_load[2] = w_accept && (sel == SEL_C);
  assign w_drop    = w_accept && (sel == SEL_INV);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_pulse <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_err_pulse <= w_drop;
      if (w_drop) begin
        r_err_count <= sat_inc(r_err_count);
      end
    end
  end

  assign err_pulse = r_err_pulse;
  assign err_count = r_err_count;

  out_slot #(.WIDTH(WIDTH)) u_slot_a (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load[0]),
    .i_data  (in_data),
    .i_ready (ready_a),
    .o_data  (out_a),
    .o_valid (valid_a),
    .o_free  (w_free[0])
  );

  out_slot #(.WIDTH(WIDTH)) u_slot_b (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load[1]),
    .i_data  (in_data),
    .i_ready (ready_b),
    .o_data  (out_b),
    .o_valid (valid_b),
    .o_free  (w_free[1])
  );

  out_slot #(.WIDTH(WIDTH)) u_slot_c (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load[2]),
    .i_data  (in_data),
    .i_ready (ready_c),
    .o_data  (out_c),
    .o_valid (valid_c),
    .o_free  (w_free[2])
  );

endmodule

// File: tb/tb_demux1to3.sv
// Directed bench for demux1to3: a table of per-cycle vectors plus hand-written sequences
// for saturation, asynchronous reset and back-to-back streaming.
module tb_demux1to3;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic [1:0]  sel;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_a, out_b, out_c;
  logic        valid_a, valid_b, valid_c;
  logic        ready_a, ready_b, ready_c;
  logic        err_pulse;
  logic [7:0]  err_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  demux1to3 #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_c     (out_c),
    .valid_a   (valid_a),
    .valid_b   (valid_b),
    .valid_c   (valid_c),
    .ready_a   (ready_a),
    .ready_b   (ready_b),
    .ready_c   (ready_c),
    .err_pulse (err_pulse),
    .err_count (err_count)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  sel;
    logic        vld;
    logic [2:0]  rdy;     // {c, b, a}
    logic        exp_rdy;
    logic [2:0]  exp_val; // {c, b, a} after the edge
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic [31:0] exp_c;
    logic        exp_ep;
    logic [7:0]  exp_ec;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Case 1: one word to each output, all consumers ready
    vecs[0]  = '{32'h1,  2'b00, 1'b1, 3'b111, 1'b1, 3'b001, 32'h1,  32'h0, 32'h0,  1'b0, 8'd0};
    vecs[1]  = '{32'h2,  2'b01, 1'b1, 3'b111, 1'b1, 3'b010, 32'h1,  32'h2, 32'h0,  1'b0, 8'd0};
    vecs[2]  = '{32'h3,  2'b10, 1'b1, 3'b111, 1'b1, 3'b100, 32'h1,  32'h2, 32'h3,  1'b0, 8'd0};
    vecs[3]  = '{32'h0,  2'b00, 1'b0, 3'b111, 1'b1, 3'b000, 32'h1,  32'h2, 32'h3,  1'b0, 8'd0};
    // Case 2: backpressure on b, then drain+load in one edge
    vecs[4]  = '{32'hA,  2'b01, 1'b1, 3'b101, 1'b1, 3'b010, 32'h1,  32'hA, 32'h3,  1'b0, 8'd0};
    vecs[5]  = '{32'hB,  2'b01, 1'b1, 3'b101, 1'b0, 3'b010, 32'h1,  32'hA, 32'h3,  1'b0, 8'd0};
    vecs[6]  = '{32'hB,  2'b01, 1'b1, 3'b111, 1'b1, 3'b010, 32'h1,  32'hB, 32'h3,  1'b0, 8'd0};
    vecs[7]  = '{32'h0,  2'b01, 1'b0, 3'b101, 1'b0, 3'b010, 32'h1,  32'hB, 32'h3,  1'b0, 8'd0};
    vecs[8]  = '{32'h0,  2'b01, 1'b0, 3'b111, 1'b1, 3'b000, 32'h1,  32'hB, 32'h3,  1'b0, 8'd0};
    // Case 3: a stalled and full, c still accepts
    vecs[9]  = '{32'h11, 2'b00, 1'b1, 3'b110, 1'b1, 3'b001, 32'h11, 32'hB, 32'h3,  1'b0, 8'd0};
    vecs[10] = '{32'h22, 2'b10, 1'b1, 3'b110, 1'b1, 3'b101, 32'h11, 32'hB, 32'h22, 1'b0, 8'd0};
    vecs[11] = '{32'h33, 2'b00, 1'b1, 3'b110, 1'b0, 3'b001, 32'h11, 32'hB, 32'h22, 1'b0, 8'd0};
    vecs[12] = '{32'h0,  2'b00, 1'b0, 3'b111, 1'b1, 3'b000, 32'h11, 32'hB, 32'h22, 1'b0, 8'd0};
    // Case 4: invalid selects dropped and counted
    vecs[13] = '{32'h44, 2'b11, 1'b1, 3'b000, 1'b1, 3'b000, 32'h11, 32'hB, 32'h22, 1'b1, 8'd1};
    vecs[14] = '{32'h55, 2'b11, 1'b1, 3'b000, 1'b1, 3'b000, 32'h11, 32'hB, 32'h22, 1'b1, 8'd2};
    vecs[15] = '{32'h66, 2'b11, 1'b1, 3'b000, 1'b1, 3'b000, 32'h11, 32'hB, 32'h22, 1'b1, 8'd3};
    vecs[16] = '{32'h0,  2'b11, 1'b0, 3'b000, 1'b1, 3'b000, 32'h11, 32'hB, 32'h22, 1'b0, 8'd3};

    // Reset state, with a would-be drop presented while in reset
    rst = 1'b1;
    in_data = 32'h5;
    sel = 2'b11;
    in_valid = 1'b1;
    {ready_c, ready_b, ready_a} = 3'b111;
    tick();
    chk("rst in_ready", {31'b0, in_ready}, 32'h0);
    chk("rst valid", {29'b0, valid_c, valid_b, valid_a}, 32'h0);
    chk("rst out_a", out_a, 32'h0);
    chk("rst out_b", out_b, 32'h0);
    chk("rst out_c", out_c, 32'h0);
    chk("rst err_pulse", {31'b0, err_pulse}, 32'h0);
    chk("rst err_count", {24'b0, err_count}, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      in_data  = vecs[i].data;
      sel      = vecs[i].sel;
      in_valid = vecs[i].vld;
      {ready_c, ready_b, ready_a} = vecs[i].rdy;
      #1;
      chk($sformatf("v%0d in_ready", i), {31'b0, in_ready}, {31'b0, vecs[i].exp_rdy});
      tick();
      chk($sformatf("v%0d valid", i), {29'b0, valid_c, valid_b, valid_a},
          {29'b0, vecs[i].exp_val});
      chk($sformatf("v%0d out_a", i), out_a, vecs[i].exp_a);
      chk($sformatf("v%0d out_b", i), out_b, vecs[i].exp_b);
      chk($sformatf("v%0d out_c", i), out_c, vecs[i].exp_c);
      chk($sformatf("v%0d err_pulse", i), {31'b0, err_pulse}, {31'b0, vecs[i].exp_ep});
      chk($sformatf("v%0d err_count", i), {24'b0, err_count}, {24'b0, vecs[i].exp_ec});
    end

    // Saturation: 297 more drops makes 300 in total
    sel = 2'b11;
    in_valid = 1'b1;
    for (int i = 0; i < 297; i++) tick();
    chk("sat err_count", {24'b0, err_count}, 32'd255);
    chk("sat err_pulse", {31'b0, err_pulse}, 32'h1);
    chk("sat valid", {29'b0, valid_c, valid_b, valid_a}, 32'h0);
    in_valid = 1'b0;
    tick();
    chk("sat pulse end", {31'b0, err_pulse}, 32'h0);
    chk("sat hold", {24'b0, err_count}, 32'd255);

    // Case 5: asynchronous reset with b holding a word
    in_data = 32'h77;
    sel = 2'b01;
    in_valid = 1'b1;
    {ready_c, ready_b, ready_a} = 3'b101;
    tick();
    chk("c5 valid_b set", {31'b0, valid_b}, 32'h1);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("c5 async valid_b", {31'b0, valid_b}, 32'h0);
    chk("c5 async out_b", out_b, 32'h0);
    chk("c5 async err_count", {24'b0, err_count}, 32'h0);
    chk("c5 async in_ready", {31'b0, in_ready}, 32'h0);
    #2;
    rst = 1'b0;
    in_data = 32'h88;
    sel = 2'b01;
    in_valid = 1'b1;
    {ready_c, ready_b, ready_a} = 3'b111;
    #1;
    chk("c5 post in_ready", {31'b0, in_ready}, 32'h1);
    tick();
    chk("c5 post valid_b", {31'b0, valid_b}, 32'h1);
    chk("c5 post out_b", out_b, 32'h88);

    // Case 6: back-to-back stream to a
    sel = 2'b00;
    for (int i = 0; i < 8; i++) begin
      in_data = 32'h100 + i;
      in_valid = 1'b1;
      #1;
      chk($sformatf("c6 in_ready %0d", i), {31'b0, in_ready}, 32'h1);
      tick();
      chk($sformatf("c6 valid_a %0d", i), {31'b0, valid_a}, 32'h1);
      chk($sformatf("c6 out_a %0d", i), out_a, 32'h100 + i);
    end
    in_valid = 1'b0;
    tick();
    chk("c6 drained", {31'b0, valid_a}, 32'h0);
    chk("c6 out_a hold", out_a, 32'h107);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
